// File: rtl/i_ap_mac_acc_if.sv
// Handshake bundle for the saturating MAC accumulator: start/bias, term beats
// upstream, result with valid/ready downstream, plus status.
interface i_ap_mac_acc_if #(
  parameter int bitlength = 16,
  parameter int cntlength = 10
);
  logic                        start;
  logic signed [bitlength-1:0] bias;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [bitlength-1:0] w;
  logic                        v;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [bitlength-1:0] sum;
  logic                        sat_flag;
  logic [cntlength-1:0]        term_cnt;
  logic                        busy;

  modport master (
    output start, bias, in_valid, w, v, in_last, out_ready,
    input  in_ready, out_valid, sum, sat_flag, term_cnt, busy
  );

  modport slave (
    input  start, bias, in_valid, w, v, in_last, out_ready,
    output in_ready, out_valid, sum, sat_flag, term_cnt, busy
  );
endinterface

// File: rtl/i_ap_mac_acc.sv
// Saturating accumulator of binary-gated weights: acc = bias + sum(v_i * w_i),
// clamped to +/-Inf on every step, with a term counter and sticky saturation flag.
module i_ap_mac_acc #(
  parameter int                          bitlength = 16,
  parameter logic signed [bitlength-1:0] Inf       = 16'b0111_1111_1111_1111,
  parameter int                          cntlength = 10
) (
  input  logic           clk,
  input  logic           rst,
  i_ap_mac_acc_if.slave  bus
);

  localparam logic signed [bitlength-1:0] NegInf = -Inf;
  localparam int                          Msb    = bitlength - 1;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t                      state_q;
  logic signed [bitlength-1:0] acc_q;
  logic                        sat_q;
  logic [cntlength-1:0]        cnt_q;
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic                        busy_q;

  logic signed [bitlength-1:0] add_t;
  logic signed [bitlength-1:0] sat_sum_d;
  logic                        clamp_d;
  logic                        pos_ovf;
  logic                        neg_ovf;

  // The single bitlength-bit adder; overflow is read from operand and result signs.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    add_t     = acc_q + bus.w;
    pos_ovf   = ~acc_q[Msb] & ~bus.w[Msb] &  add_t[Msb];
    neg_ovf   =  acc_q[Msb] &  bus.w[Msb] & ~add_t[Msb];
    clamp_d   = pos_ovf | neg_ovf;
    sat_sum_d = add_t;
    if (pos_ovf) begin
      sat_sum_d = Inf;
    end else if (neg_ovf) begin
      sat_sum_d = NegInf;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= ACC;
            acc_q      <= bus.bias;
            sat_q      <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ACC: begin
          if (bus.in_valid) begin
            // Counter saturates at all-ones so long vectors never alias to small counts.
            if (cnt_q != '1) begin
              cnt_q <= cnt_q + 1'b1;
            end
            if (bus.v) begin
              acc_q <= sat_sum_d;
              if (clamp_d) begin
                sat_q <= 1'b1;
              end
            end
            if (bus.in_last) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = acc_q;
  assign bus.sat_flag  = sat_q;
  assign bus.term_cnt  = cnt_q;

endmodule

// File: tb/tb_i_ap_mac_acc.sv
// Directed bench for i_ap_mac_acc: a driver pushes hand-computed results into a
// scoreboard queue, a monitor pops and compares whenever a result is consumed.
module tb_i_ap_mac_acc;

  typedef struct {
    logic signed [15:0] sum;
    logic               sat;
    logic [9:0]         cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  i_ap_mac_acc_if #(.bitlength(16), .cntlength(10)) bus ();

  i_ap_mac_acc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic signed [15:0] b);
    bus.start = 1'b1;
    bus.bias  = b;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic beat(input logic signed [15:0] wt, input logic vis, input logic last);
    bus.in_valid = 1'b1;
    bus.w        = wt;
    bus.v        = vis;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic push(input logic signed [15:0] s, input logic st, input logic [9:0] c);
    exp_t e;
    e.sum = s;
    e.sat = st;
    e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // Monitor: a result is consumed at the next rising edge when valid and ready are both high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("result_sum", bus.sum, e.sum);
          check("result_sat", bus.sat_flag, e.sat);
          check("result_cnt", bus.term_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    bus.start     = 1'b0;
    bus.bias      = '0;
    bus.in_valid  = 1'b0;
    bus.w         = '0;
    bus.v         = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset, with start asserted alongside to confirm reset wins.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.bias  = 16'sd55;
    tick();
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_sat", bus.sat_flag, 0);
    check("rst_cnt", bus.term_cnt, 0);
    bus.start = 1'b0;
    rst       = 1'b0;
    tick();

    // Basic accumulation: 10 + 5 - 3 + 7 = 19, four beats.
    do_start(16'sd10);
    check("acc_busy", bus.busy, 1);
    check("acc_in_ready", bus.in_ready, 1);
    beat(16'sd5, 1'b1, 1'b0);
    beat(-16'sd3, 1'b1, 1'b0);
    beat(16'sd100, 1'b0, 1'b0);
    check("basic_no_valid_early", bus.out_valid, 0);
    beat(16'sd7, 1'b1, 1'b1);
    check("basic_latency", bus.out_valid, 1);
    check("basic_in_ready_done", bus.in_ready, 0);
    push(16'sd19, 1'b0, 10'd4);
    consume();

    // Positive saturation: 32760 + 10 clamps to 32767, then -5 gives 32762.
    do_start(16'sd32760);
    beat(16'sd10, 1'b1, 1'b0);
    check("pos_clamp_sum", bus.sum, 32767);
    check("pos_clamp_flag", bus.sat_flag, 1);
    beat(-16'sd5, 1'b1, 1'b1);
    push(16'sd32762, 1'b1, 10'd2);
    consume();

    // Negative saturation: -32760 - 100 clamps to -32767.
    do_start(-16'sd32760);
    beat(-16'sd100, 1'b1, 1'b1);
    push(-16'sd32767, 1'b1, 10'd1);
    consume();

    // Handshake and stall: start ignored in ACC/DONE, gaps leave acc alone.
    do_start(16'sd3);
    bus.start = 1'b1;
    bus.bias  = 16'sd999;
    tick();
    bus.start = 1'b0;
    check("start_in_acc_ignored", bus.sum, 3);
    beat(16'sd4, 1'b1, 1'b0);
    bus.w = 16'sd1000;
    bus.v = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("gap_sum", bus.sum, 7);
    check("gap_cnt", bus.term_cnt, 1);
    beat(16'sd2, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 2);
      tick();
      check("stall_valid", bus.out_valid, 1);
      check("stall_sum", bus.sum, 9);
      check("stall_cnt", bus.term_cnt, 2);
    end
    bus.start = 1'b0;
    push(16'sd9, 1'b0, 10'd2);
    bus.start = 1'b1;
    consume();
    bus.start = 1'b0;
    check("consume_to_idle", bus.busy, 0);
    check("consume_no_restart", bus.in_ready, 0);

    // Reset mid-operation abandons the vector; a fresh one still works.
    do_start(16'sd50);
    beat(16'sd1, 1'b1, 1'b0);
    beat(16'sd1, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_sum", bus.sum, 0);
    check("midrst_cnt", bus.term_cnt, 0);
    do_start(16'sd1);
    beat(16'sd2, 1'b1, 1'b1);
    push(16'sd3, 1'b0, 10'd1);
    consume();

    // Counter hold: 1030 gated-off beats leave sum at bias, count at 1023.
    do_start(-16'sd7);
    bus.in_valid = 1'b1;
    bus.v        = 1'b0;
    for (int i = 0; i < 1030; i++) begin
      bus.w       = 16'($urandom);
      bus.in_last = (i == 1029);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    push(-16'sd7, 1'b0, 10'd1023);
    consume();

    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i_ap_mac_acc.md
I_AP_MAC_ACC -- requirements
Module: i_ap_mac_acc

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- bitlength, 16, datapath width.
- Inf, 16'b0111_1111_1111_1111, positive saturation value; the negative limit is -Inf.
- cntlength, 10, width of the term counter.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- start, in, 1, begin a new accumulation; sampled only in IDLE.
- bias, in, signed bitlength, initial accumulator value; captured with start.
- in_valid, in, 1, a term beat is presented.
- in_ready, out, 1, the block accepts a term beat.
- w, in, signed bitlength, weight of the current term.
- v, in, 1, binary visible-unit state gating w.
- in_last, in, 1, marks the final term beat of the vector.
- out_valid, out, 1, the result is available.
- out_ready, in, 1, downstream consumes the result.
- sum, out, signed bitlength, saturated weighted sum.
- sat_flag, out, 1, sticky: saturation occurred during this accumulation.
- term_cnt, out, cntlength, number of beats accepted in this accumulation.
- busy, out, 1, high whenever the state is not IDLE.

Function
REQ-003 The FSM SHALL have three states, IDLE, ACC and DONE, with these transitions:
- IDLE to ACC when start=1.
- ACC to DONE on an accepted beat with in_last=1.
- DONE to IDLE when out_ready=1.

REQ-004 On the IDLE-to-ACC transition, acc SHALL load bias, and sat_flag and term_cnt SHALL clear.

REQ-005 start SHALL be ignored in ACC and DONE.

REQ-006 in_ready SHALL be 1 exactly in ACC; a beat is accepted when in_valid and in_ready are both 1 at a rising clk edge.

REQ-007 On an accepted beat with v=1, acc SHALL become sat(acc + w); with v=0, acc SHALL be unchanged.

REQ-008 term_cnt SHALL increment on every accepted beat, regardless of v, and SHALL hold at all-ones rather than wrap.

REQ-009 sat(a+b) SHALL be computed on the bitlength-bit two's-complement sum t, as follows:
- Both operands non-negative and t negative: result is Inf.
- Both operands negative and t non-negative: result is -Inf.
- Otherwise: result is t.

REQ-010 sat_flag SHALL set on any accepted beat where REQ-009 clamps the result, and SHALL stay set until the next start.

REQ-011 The final beat (in_last=1) SHALL be accumulated exactly like the other beats.

REQ-012 out_valid SHALL be 1 exactly in DONE, beginning the cycle after the in_last beat is accepted (latency 1 cycle).

REQ-013 sum SHALL continuously reflect acc; while out_valid=1, sum, sat_flag and term_cnt SHALL be stable until consumed.

REQ-014 The result is consumed when out_valid and out_ready are both 1; after consumption the next cycle is IDLE, and start is sampled from then on (no back-to-back start on the consume cycle).

REQ-015 in_valid, w, v and in_last SHALL be ignored outside ACC.

REQ-016 out_ready SHALL be ignored outside DONE.

REQ-017 A bitlength-bit adder SHALL be the only arithmetic resource, with no wider intermediate accumulator.

Reset
REQ-018 With rst=1 at a rising clk edge, the block SHALL enter IDLE and set acc=0, sum=0, sat_flag=0, term_cnt=0, out_valid=0, in_ready=0 and busy=0.

REQ-019 rst SHALL take priority over start, beats and out_ready on the same edge.

REQ-020 rst during ACC or DONE SHALL abandon the accumulation, with no out_valid pulse.

REQ-021 Outputs SHALL be defined (not X) from the first edge with rst=1.

Verification
REQ-022 Basic accumulation: bias=10; beats (w,v) = (5,1), (-3,1), (100,0), then (7,1) with last. Required: out_valid on the cycle after the last beat, sum=19, term_cnt=4, sat_flag=0.

REQ-023 Positive saturation: bias=32760; beats (10,1), then (-5,1) with last. Required: clamp to 32767 after the first beat, then sum=32762 and sat_flag=1.

REQ-024 Negative saturation: bias=-32760; beat (-100,1) with last. Required: sum=-32767 and sat_flag=1.

REQ-025 Handshake and stall:
- Hold out_ready=0 for 5 cycles: out_valid, sum and term_cnt remain stable.
- start pulses during ACC and DONE are ignored.
- in_valid gaps do not change acc.

REQ-026 Reset mid-operation: assert rst after 2 beats of a 4-beat vector. Required: next cycle IDLE, out_valid=0, sum=0, term_cnt=0; a new start with bias=1 and one beat (2,1) with last gives sum=3.

REQ-027 Counter hold: 1030 accepted beats with v=0 and cntlength=10. Required: term_cnt=1023 and sum=bias.
